traffic_light_param: RTL and testbench
======================================

Name: traffic_light_param

Overview:
Parametrised single-approach traffic light controller. It is the next generation of the fixed-timing NS/EW light: phase durations and start offset are parameters, and emergency preemption holds all-red for as long as the request persists. One instance drives each approach. NS and EW use the same module with different START_PHASE/START_COUNT so their timing interlocks.

Parameters:
LEFT_CYC, 5, cycles of left-turn+red phase (>=1)
GREEN_CYC, 10, cycles of green phase (>=1)
YELLOW_CYC, 3, cycles of yellow phase (>=1)
RED_CYC, 18, cycles of red phase (>=1)
START_PHASE, 0, phase entered on reset (0..3)
START_COUNT, 0, count value loaded on reset (< duration of START_PHASE)
CNT_W, 5, counter width; must hold max(*_CYC)-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
emergency  input  1  emergency-vehicle request, sampled on clk
out  output  4  lamps: [3]=left arrow, [2]=green, [1]=yellow, [0]=red
phase  output  3  current state encoding (0 LEFT, 1 GREEN, 2 YELLOW, 3 RED, 4 ALLSTOP)
preempted  output  1  high while in ALLSTOP
cycle_done  output  1  one-cycle pulse in the first cycle after RED wraps to the next phase

Behaviour:
- Registers: state[2:0], count[CNT_W-1:0], saved_state[1:0], saved_count, cycle_done.
- Reset (rst=1 at posedge): state=START_PHASE, count=START_COUNT, saved_*=0, cycle_done=0. rst overrides emergency.
- out, phase and preempted decode combinationally from state. LEFT=4'b1001, GREEN=4'b0100, YELLOW=4'b0010, RED=4'b0001, ALLSTOP=4'b0001.
- Normal phase P with duration D: if count<D-1, count increments. Otherwise count=0 and state advances: LEFT->GREEN->YELLOW->RED->LEFT. Each phase shows for exactly D cycles; the full loop is the sum of the four durations (36 cycles at defaults).
- Preemption: emergency=1 at a posedge while state!=ALLSTOP:
  - saved_state=state and saved_count=count, with count not advanced;
  - state=ALLSTOP next cycle;
  - emergency has priority over a phase-end transition in the same cycle.
- ALLSTOP:
  - lasts a minimum of 1 cycle;
  - stays while emergency=1;
  - on the first posedge with emergency=0, state=saved_state and count=saved_count;
  - the interrupted cycle is not credited, so the phase resumes and shows its remaining cycles plus the one repeated.
- Re-preemption: emergency high again in the first resumed cycle re-enters ALLSTOP the following cycle, saving the resumed state and count.
- cycle_done=1 for exactly one cycle after a RED->next transition. It is not asserted on exit from ALLSTOP.
- Illegal state (5..7): next state is RED with count=0, which is the safe state.
- Elaboration check: each *_CYC>=1 and fits CNT_W; START_COUNT is below the start-phase duration.

Optional Feature:
TL_LEFT_PHASE_EN
- Defined: the LEFT phase is present as described above.
- Undefined:
  - LEFT is removed and RED advances directly to GREEN;
  - a START_PHASE of 0 maps to GREEN;
  - out[3] is tied to 0;
  - the loop length becomes GREEN_CYC+YELLOW_CYC+RED_CYC;
  - cycle_done pulses on the RED->GREEN transition.

Decomposition:
- Package tl_pkg:
  - phase encodings (PH_LEFT, PH_GREEN, PH_YELLOW, PH_RED, PH_ALLSTOP);
  - lamp constants (LAMP_LEFT=4'b1001, LAMP_GREEN=4'b0100, LAMP_YELLOW=4'b0010, LAMP_RED=4'b0001);
  - a function returning the duration of a given phase.
- Sub-module tl_phase_timer is natural. It takes the phase duration and returns count plus a last-cycle flag, with load and freeze controls for preemption.
- State sequencing and save/restore stay in the top.

Test Plan:
- Defaults, rst for 2 cycles then release -> out=1001 for 5 cycles, 0100 for 10, 0010 for 3, 0001 for 18. Then back to 1001, with cycle_done high in that first cycle; period 36.
- Emergency pulsed 1 cycle while GREEN at count=3 -> next cycle out=0001 and preempted=1 for 1 cycle. Then GREEN for 7 more cycles (count 3..9), then YELLOW.
- Emergency held 6 cycles during RED at count=17 -> ALLSTOP for 6 cycles, then RED for 1 cycle, then LEFT with cycle_done=1.
- rst and emergency both high at a posedge -> state=START_PHASE and preempted=0. Instance with START_PHASE=3, START_COUNT=8 -> RED for 10 cycles after reset, then LEFT.
- All durations=1 with TL_LEFT_PHASE_EN undefined -> out sequence 0100, 0010, 0001 repeating, out[3] never high, cycle_done every 3rd cycle.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared phase encodings, lamp patterns and phase-duration lookup for the
// parametrised traffic light.
package tl_pkg;

  typedef enum logic [2:0] {
    PH_LEFT    = 3'd0,
    PH_GREEN   = 3'd1,
    PH_YELLOW  = 3'd2,
    PH_RED     = 3'd3,
    PH_ALLSTOP = 3'd4
  } phase_e;

  localparam logic [3:0] LAMP_LEFT   = 4'b1001;
  localparam logic [3:0] LAMP_GREEN  = 4'b0100;
  localparam logic [3:0] LAMP_YELLOW = 4'b0010;
  localparam logic [3:0] LAMP_RED    = 4'b0001;

  // ALLSTOP and illegal encodings report 1 so the timer always has a sane limit.
  function automatic int phase_dur(input logic [2:0] ph, input int left_c,
                                   input int green_c, input int yellow_c,
                                   input int red_c);
    case (ph)
      3'd0:    return left_c;
      3'd1:    return green_c;
      3'd2:    return yellow_c;
      3'd3:    return red_c;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase cycle counter: counts 0..dur-1 and wraps, with a load port for
// restoring a saved position and a freeze port that holds the count.
module tl_phase_timer #(
  parameter int               CNT_W   = 5,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             freeze,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = (count >= dur - 1'b1);

  always_ff @(posedge clk) begin
    if (rst)         count <= RST_VAL;
    else if (load)   count <= load_val;
    else if (freeze) count <= count;
    else if (last)   count <= '0;
    else             count <= count + 1'b1;
  end

endmodule

// File: rtl/traffic_light_param.sv
// Single-approach traffic light with parametrised phase timing and emergency
// all-red preemption. Define TL_LEFT_PHASE_EN to include the LEFT phase.
module traffic_light_param
  import tl_pkg::*;
#(
  parameter int LEFT_CYC    = 5,
  parameter int GREEN_CYC   = 10,
  parameter int YELLOW_CYC  = 3,
  parameter int RED_CYC     = 18,
  parameter int START_PHASE = 0,
  parameter int START_COUNT = 0,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  output logic [3:0] out,
  output logic [2:0] phase,
  output logic       preempted,
  output logic       cycle_done
);

`ifdef TL_LEFT_PHASE_EN
  localparam bit         LEFT_EN  = 1'b1;
  localparam logic [2:0] START_ST = 3'(START_PHASE);
`else
  localparam bit         LEFT_EN  = 1'b0;
  localparam logic [2:0] START_ST = (START_PHASE == 0) ? PH_GREEN : 3'(START_PHASE);
`endif
  localparam int START_DUR = phase_dur(START_ST, LEFT_CYC, GREEN_CYC, YELLOW_CYC, RED_CYC);

  if (LEFT_CYC < 1 || LEFT_CYC > (1 << CNT_W) || GREEN_CYC < 1 || GREEN_CYC > (1 << CNT_W) ||
      YELLOW_CYC < 1 || YELLOW_CYC > (1 << CNT_W) || RED_CYC < 1 || RED_CYC > (1 << CNT_W))
  begin : g_bad_dur
    $error("traffic_light_param: phase duration below 1 or too wide for CNT_W");
  end
  if (START_PHASE < 0 || START_PHASE > 3 || START_COUNT < 0 || START_COUNT >= START_DUR)
  begin : g_bad_start
    $error("traffic_light_param: START_PHASE/START_COUNT out of range");
  end

  logic [2:0]       state, state_nxt, succ;
  logic [1:0]       saved_state;
  logic [CNT_W-1:0] saved_count, count, load_val, dur;
  logic             load, freeze, save, last, legal;

  assign dur = CNT_W'(phase_dur(state, LEFT_CYC, GREEN_CYC, YELLOW_CYC, RED_CYC));

  tl_phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(START_COUNT))) u_timer (
    .clk(clk), .rst(rst), .load(load), .freeze(freeze),
    .load_val(load_val), .dur(dur), .count(count), .last(last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= START_ST;
      saved_state <= '0;
      saved_count <= '0;
      cycle_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cycle_done <= (state == PH_RED) && last && !emergency;
      if (save) begin
        saved_state <= state[1:0];
        saved_count <= count;
      end
    end
  end

  always_comb begin
    legal = (state == PH_GREEN) || (state == PH_YELLOW) || (state == PH_RED) ||
            (LEFT_EN && state == PH_LEFT);
    case (state)
      PH_LEFT:   succ = PH_GREEN;
      PH_GREEN:  succ = PH_YELLOW;
      PH_YELLOW: succ = PH_RED;
      default:   succ = LEFT_EN ? PH_LEFT : PH_GREEN;
    endcase
    state_nxt = state;
    load      = 1'b0;
    load_val  = '0;
    freeze    = 1'b0;
    save      = 1'b0;
    if (state == PH_ALLSTOP) begin
      // Resume at the interrupted count so that cycle is shown again.
      if (emergency) begin
        freeze = 1'b1;
      end else begin
        state_nxt = {1'b0, saved_state};
        load      = 1'b1;
        load_val  = saved_count;
      end
    end else if (!legal) begin
      state_nxt = PH_RED;
      load      = 1'b1;
    end else if (emergency) begin
      state_nxt = PH_ALLSTOP;
      freeze    = 1'b1;
      save      = 1'b1;
    end else if (last) begin
      state_nxt = succ;
    end
  end

  always_comb begin
    case (state)
      PH_LEFT:   out = LAMP_LEFT;
      PH_GREEN:  out = LAMP_GREEN;
      PH_YELLOW: out = LAMP_YELLOW;
      default:   out = LAMP_RED;
    endcase
    if (!LEFT_EN) out[3] = 1'b0;
    phase     = state;
    preempted = (state == PH_ALLSTOP);
  end

endmodule

// File: tb/tb_traffic_light_param.sv
module tb_traffic_light_param;

`ifdef TL_LEFT_PHASE_EN
  localparam bit LEFT_EN = 1'b1;
`else
  localparam bit LEFT_EN = 1'b0;
`endif
  localparam int L    = LEFT_EN ? 5 : 0;
  localparam int P    = L + 31;
  localparam int PER2 = LEFT_EN ? 4 : 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, em0;
  logic em_zero = 1'b0;
  logic [3:0] out0, out1, out2;
  logic [2:0] ph0, ph1, ph2;
  logic       pre0, pre1, pre2, cd0, cd1, cd2;

  traffic_light_param dut0 (
    .clk(clk), .rst(rst), .emergency(em0), .out(out0), .phase(ph0),
    .preempted(pre0), .cycle_done(cd0));

  traffic_light_param #(.START_PHASE(3), .START_COUNT(8)) dut1 (
    .clk(clk), .rst(rst), .emergency(em_zero), .out(out1), .phase(ph1),
    .preempted(pre1), .cycle_done(cd1));

  traffic_light_param #(.LEFT_CYC(1), .GREEN_CYC(1), .YELLOW_CYC(1), .RED_CYC(1),
                        .CNT_W(1)) dut2 (
    .clk(clk), .rst(rst), .emergency(em_zero), .out(out2), .phase(ph2),
    .preempted(pre2), .cycle_done(cd2));

  typedef struct {
    int         inst;
    int         t;
    logic [3:0] out;
    logic [2:0] ph;
    logic       pre;
    logic       cd;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [3:0] lamp(int ph);
    case (ph)
      0:       return 4'b1001;
      1:       return 4'b0100;
      2:       return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic push(int inst, int t, int ph, bit cd);
    exp_t e;
    e.inst = inst; e.t = t; e.out = lamp(ph); e.ph = 3'(ph);
    e.pre = (ph == 4); e.cd = cd;
    q.push_back(e);
  endtask

  function automatic int ph0_at(int pos);
    if (pos < L)       return 0;
    if (pos < L + 10)  return 1;
    if (pos < L + 13)  return 2;
    return 3;
  endfunction

  function automatic int ph2_at(int t);
    return LEFT_EN ? (t % 4) : (1 + t % 3);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [8:0] act, want;
      e = q.pop_front();
      case (e.inst)
        0:       act = {out0, ph0, pre0, cd0};
        1:       act = {out1, ph1, pre1, cd1};
        default: act = {out2, ph2, pre2, cd2};
      endcase
      want = {e.out, e.ph, e.pre, e.cd};
      n_tests++;
      if (act !== want) begin
        n_fail++;
        $display("FAIL dut%0d t=%0d: got out=%b phase=%0d pre=%b cd=%b, expected out=%b phase=%0d pre=%b cd=%b",
                 e.inst, e.t, act[8:5], act[4:2], act[1], act[0],
                 want[8:5], want[4:2], want[1], want[0]);
      end
    end
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: simulation did not finish within the expected time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int pos, stage, hold, done_t;
    bit allstop, cdn, em, just_resumed;
    rst = 1'b1; em0 = 1'b0;
    @(posedge clk); #1;
    push(0, -2, ph0_at(0), 1'b0);
    push(1, -2, 3, 1'b0);
    push(2, -2, ph2_at(0), 1'b0);
    em0 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ph0 !== 3'(ph0_at(0)) || pre0 !== 1'b0 || out0 !== lamp(ph0_at(0))) begin
      n_fail++;
      $display("FAIL reset+emergency: got out=%b phase=%0d pre=%b, expected out=%b phase=%0d pre=0",
               out0, ph0, pre0, lamp(ph0_at(0)), ph0_at(0));
    end
    rst = 1'b0; em0 = 1'b0;
    pos = 0; allstop = 0; cdn = 0; stage = 0; hold = 0; done_t = 0; just_resumed = 0;
    for (int t = 0; t < 400; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      push(0, t, allstop ? 4 : ph0_at(pos), cdn);
      if (t < 12) begin
        push(1, t, (t < 10) ? 3 : (LEFT_EN ? 0 : 1), t == 10);
        push(2, t, ph2_at(t), (t > 0) && (t % PER2 == 0));
      end
      em = 1'b0;
      case (stage)
        0: if (t >= P + 2 && !allstop && pos == L + 3) begin em = 1'b1; stage = 1; end
        1: if (!allstop && pos == P - 1) begin em = 1'b1; hold = 5; stage = 2; end
        2: if (hold > 0) begin em = 1'b1; hold--; end else stage = 3;
        3: if (!allstop && pos == L + 11) begin em = 1'b1; stage = 4; end
        4: if (just_resumed) begin em = 1'b1; stage = 5; done_t = t; end
        default: ;
      endcase
      em0 = em;
      just_resumed = 1'b0;
      if (em) begin
        allstop = 1'b1; cdn = 1'b0;
      end else if (allstop) begin
        allstop = 1'b0; cdn = 1'b0; just_resumed = 1'b1;
      end else begin
        pos = (pos + 1) % P;
        cdn = (pos == 0);
      end
      if (stage == 5 && t > done_t + 20) break;
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
